// File: rtl/cube_move_executor.sv
// 2x2 cube move executor: applies quarter-turn moves from a move stream to a 24-sticker cube state.
// Optional half turns U2/R2/F2 on codes 13-15 are enabled by defining CUBE_HALF_TURN_EN.
module cube_move_executor (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_valid,
    input  logic [3:0]  move,
    output logic        move_ready,
    output logic [71:0] cube_state,
    output logic        solved,
    output logic        busy,
    output logic [7:0]  move_count,
    output logic        err
);

    typedef enum logic {IDLE, STEP} state_t;

    localparam logic [71:0] SOLVED_CUBE = {{4{3'd5}}, {4{3'd4}}, {4{3'd3}},
                                           {4{3'd2}}, {4{3'd1}}, {4{3'd0}}};

    state_t      state, state_nxt;
    logic [1:0]  turns_left, turns_left_nxt;
    logic [2:0]  face, face_nxt;
    logic [71:0] cube_nxt;
    logic [7:0]  count_nxt;
    logic        err_nxt;

    logic [2:0]  dec_face;
    logic [1:0]  dec_extra;
    logic        dec_illegal;
    logic [2:0]  turn_face;
    logic [71:0] turned;

    // Gather form: new sticker i takes old sticker src[i]. Layout U,D,L,R,F,B = stickers 0-3 .. 20-23.
    function automatic logic [71:0] turn_cw(input logic [71:0] s, input logic [2:0] f);
        logic [4:0]  src [24];
        logic [71:0] r;
        int          fb;
        for (int i = 0; i < 24; i++) src[i] = 5'(i);
        if (f <= 3'd5) begin
            fb = 4 * int'(f);
            for (int i = 0; i < 4; i++) src[fb + i] = 5'(fb + (i + 3) % 4);
        end
        case (f)
            3'd0: begin
                src[8]  = 5'd16; src[9]  = 5'd17; src[20] = 5'd8;  src[21] = 5'd9;
                src[12] = 5'd20; src[13] = 5'd21; src[16] = 5'd12; src[17] = 5'd13;
            end
            3'd1: begin
                src[15] = 5'd19; src[14] = 5'd18; src[23] = 5'd15; src[22] = 5'd14;
                src[11] = 5'd23; src[10] = 5'd22; src[19] = 5'd11; src[18] = 5'd10;
            end
            3'd2: begin
                src[16] = 5'd0;  src[19] = 5'd3;  src[4]  = 5'd16; src[7]  = 5'd19;
                src[22] = 5'd4;  src[21] = 5'd7;  src[3]  = 5'd21; src[0]  = 5'd22;
            end
            3'd3: begin
                src[1]  = 5'd17; src[2]  = 5'd18; src[23] = 5'd1;  src[20] = 5'd2;
                src[6]  = 5'd20; src[5]  = 5'd23; src[17] = 5'd5;  src[18] = 5'd6;
            end
            3'd4: begin
                src[12] = 5'd3;  src[15] = 5'd2;  src[5]  = 5'd12; src[4]  = 5'd15;
                src[10] = 5'd5;  src[9]  = 5'd4;  src[2]  = 5'd9;  src[3]  = 5'd10;
            end
            3'd5: begin
                src[8]  = 5'd1;  src[11] = 5'd0;  src[7]  = 5'd8;  src[6]  = 5'd11;
                src[14] = 5'd7;  src[13] = 5'd6;  src[0]  = 5'd13; src[1]  = 5'd14;
            end
            default: ;
        endcase
        for (int i = 0; i < 24; i++) r[3*i +: 3] = s[3*int'(src[i]) +: 3];
        return r;
    endfunction

    always_comb begin
        dec_face    = 3'd0;
        dec_extra   = 2'd0;
        dec_illegal = 1'b0;
        case (move)
            4'd0: ;
            4'd1, 4'd7:  dec_face = 3'd0;
            4'd2, 4'd8:  dec_face = 3'd1;
            4'd3, 4'd9:  dec_face = 3'd2;
            4'd4, 4'd10: dec_face = 3'd3;
            4'd5, 4'd11: dec_face = 3'd4;
            4'd6, 4'd12: dec_face = 3'd5;
`ifdef CUBE_HALF_TURN_EN
            4'd13: dec_face = 3'd0;
            4'd14: dec_face = 3'd3;
            4'd15: dec_face = 3'd4;
`endif
            default: dec_illegal = 1'b1;
        endcase
        // Counter-clockwise is three clockwise turns; half turn is two.
        if (move >= 4'd7 && move <= 4'd12) dec_extra = 2'd2;
`ifdef CUBE_HALF_TURN_EN
        if (move >= 4'd13) dec_extra = 2'd1;
`endif
    end

    assign turn_face  = (state == STEP) ? face : dec_face;
    assign turned     = turn_cw(cube_state, turn_face);
    assign move_ready = (state == IDLE);
    assign busy       = (state == STEP);

    always_comb begin
        state_nxt      = state;
        turns_left_nxt = turns_left;
        face_nxt       = face;
        cube_nxt       = cube_state;
        count_nxt      = move_count;
        err_nxt        = err;
        case (state)
            IDLE: begin
                if (move_valid) begin
                    if (dec_illegal) begin
                        err_nxt = 1'b1;
                    end else if (move != 4'd0) begin
                        cube_nxt = turned;
                        if (move_count != 8'hFF) count_nxt = move_count + 8'd1;
                        if (dec_extra != 2'd0) begin
                            state_nxt      = STEP;
                            turns_left_nxt = dec_extra;
                            face_nxt       = dec_face;
                        end
                    end
                end
            end
            STEP: begin
                cube_nxt       = turned;
                turns_left_nxt = turns_left - 2'd1;
                if (turns_left == 2'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            turns_left <= 2'd0;
            face       <= 3'd0;
            cube_state <= SOLVED_CUBE;
            move_count <= 8'd0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            turns_left <= turns_left_nxt;
            face       <= face_nxt;
            cube_state <= cube_nxt;
            move_count <= count_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        solved = 1'b1;
        for (int f = 0; f < 6; f++)
            for (int i = 1; i < 4; i++)
                if (cube_state[3*(4*f+i) +: 3] != cube_state[3*(4*f) +: 3]) solved = 1'b0;
    end

endmodule

// File: doc/cube_move_executor.md
CUBE_MOVE_EXECUTOR -- requirements
Module: cube_move_executor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port move_valid, input, 1 bit: move code offered this cycle.
REQ-004 SHALL have port move, input, 4 bits: move code, this is the move stream driven by cube_solver.
REQ-005 SHALL have port move_ready, output, 1 bit: executor can accept a move this cycle.
REQ-006 SHALL have port cube_state, output, 72 bits: 24 stickers x 3-bit colour, sticker s at bits [3s+2:3s].
REQ-007 SHALL have port solved, output, 1 bit: every face uniform in colour.
REQ-008 SHALL have port busy, output, 1 bit: multi-step move in progress.
REQ-009 SHALL have port move_count, output, 8 bits: accepted legal non-no-op moves.
REQ-010 SHALL have port err, output, 1 bit: sticky, set on illegal code.

Function
REQ-011 SHALL model a 2x2 cube: faces U,D,L,R,F,B = 0..5; face f owns stickers 4f..4f+3, clockwise from top-left viewed facing the face; solved colour of face f = f.
REQ-012 SHALL accept a move on a cycle where move_valid and move_ready are both 1; no other cycle consumes a move.
REQ-013 SHALL decode codes: 0 no-op; 1-6 clockwise quarter turn U,D,L,R,F,B; 7-12 counter-clockwise quarter turn U,D,L,R,F,B; 13-15 per REQ-024.
REQ-014 SHALL implement one clockwise quarter-turn permutation per face (face stickers rotate, 8 adjacent edge stickers cycle), applied in a single cycle.
REQ-015 SHALL execute clockwise moves in 1 cycle: cube_state updated on the accepting edge; move_ready stays 1.
REQ-016 SHALL execute counter-clockwise moves as 3 successive clockwise quarter turns: first on the accepting edge, then 2 more cycles with busy=1 and move_ready=0.
REQ-017 SHALL use FSM states IDLE and STEP; IDLE->STEP on a multi-step accept, loading a 2-bit remaining-turn counter; STEP decrements per turn; STEP->IDLE when it reaches 0.
REQ-018 SHALL drive move_ready = 1 in IDLE, 0 in STEP, and busy = (state==STEP).
REQ-019 SHALL drive solved combinationally from the cube_state register, with every group 4f..4f+3 equal; the colour value itself is not checked.
REQ-020 SHALL increment move_count by 1 per accepted legal move with code 1-12 (or 13-15 if enabled), saturating at 255; no-ops and illegal codes do not count.
REQ-021 SHALL consume an illegal code, leave cube_state unchanged, and set err=1 until reset.
REQ-022 SHALL ignore move_valid while busy: no accept, no state change.

Reset
REQ-023 SHALL, when rst=0 at a clock edge (overriding any in-progress move), set cube_state to solved, state IDLE, move_ready=1, busy=0, move_count=0, err=0, solved=1.

Configuration
REQ-024 SHALL, with CUBE_HALF_TURN_EN defined, decode codes 13,14,15 as half turns U2,R2,F2, executed as 2 clockwise quarter turns (1 STEP cycle, busy=1 for 1 cycle). Without the macro, codes 13-15 are illegal per REQ-021.

Verification
REQ-025 SHALL verify reset: rst=0 for 2 cycles -> solved=1, move_count=0, err=0, move_ready=1, cube_state[2:0]=0, [71:69]=5.
REQ-026 SHALL verify move 4 (R) accepted once -> solved=0, move_count=1; then 3 more R -> solved=1, move_count=4.
REQ-027 SHALL verify move 4 then move 10 (R') -> move_ready=0 for exactly 2 cycles after R' is accepted, then solved=1, move_count=2; a move held valid during busy is accepted only on return to IDLE.
REQ-028 SHALL verify code 0 -> cube_state unchanged, move_count unchanged; code 15 with macro off -> err=1, cube_state unchanged; macro on -> F2 twice -> solved=1, move_count=2.
REQ-029 SHALL verify saturation and reset mid-move: 260 accepted U moves -> move_count=255; accept move 7, assert rst=0 on next cycle -> state IDLE, solved=1.
